// File: rtl/bus_sequencer.sv
// Frame-sliced bus sequencer: video, host and CPU slots within each CPU cycle.
// Host channels are synchronised, arbitrated round-robin and served one per frame.
module bus_sequencer #(
  parameter int CLK_DIV = 16,
  parameter int NUM_CH  = 2,
  parameter int AW      = 17,
  parameter int DW      = 8
) (
  input  logic                 clk16,
  input  logic                 reset_b,
  output logic                 phi2,
  output logic                 cpu_select,
  output logic                 video_select,
  output logic                 video_strobe,
  output logic                 host_select,
  output logic                 host_read,
  output logic                 host_write,
  input  logic [NUM_CH-1:0]    host_pending,
  output logic [NUM_CH-1:0]    host_done,
  input  logic [NUM_CH-1:0]    host_rw_b,
  input  logic [NUM_CH*AW-1:0] host_addr,
  input  logic [NUM_CH*DW-1:0] host_wdata,
  output logic [NUM_CH*DW-1:0] host_rdata,
  output logic [AW-1:0]        bus_addr_out,
  output logic                 bus_rw_b_out,
  output logic [DW-1:0]        bus_wdata,
  input  logic [DW-1:0]        bus_rdata
);

  localparam int Q    = CLK_DIV / 4;
  localparam int CNTW = $clog2(CLK_DIV);
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [CNTW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, QUEUED = 2'd1, ACTIVE = 2'd2, DONE = 2'd3} ch_state_e;

  localparam cnt_t LAST     = cnt_t'(CLK_DIV - 1);
  localparam cnt_t Q_M1     = cnt_t'(Q - 1);
  localparam cnt_t Q_LO     = cnt_t'(Q);
  localparam cnt_t SLOT_END = cnt_t'(2 * Q - 1);
  localparam cnt_t CPU_LO   = cnt_t'(2 * Q);
  localparam cnt_t PHI_LO   = cnt_t'(2 * Q + 1);

  logic                 started_q, started_d;
  cnt_t                 cnt_q, cnt_d;
  logic [NUM_CH-1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  ch_state_e            ch_state_q [NUM_CH];
  ch_state_e            ch_state_d [NUM_CH];
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d, gnt_idx_q, gnt_idx_d;
  logic                 gnt_valid_q, gnt_valid_d;
  logic                 phi2_q, phi2_d, cpu_sel_q, cpu_sel_d, vid_sel_q, vid_sel_d;
  logic                 vid_stb_q, vid_stb_d, host_sel_q, host_sel_d;
  logic                 host_rd_q, host_rd_d, host_wr_q, host_wr_d;
  logic [NUM_CH-1:0]    host_done_q, host_done_d;
  logic [NUM_CH*DW-1:0] host_rdata_q, host_rdata_d;
  logic [AW-1:0]        bus_addr_q, bus_addr_d;
  logic                 bus_rw_b_q, bus_rw_b_d;
  logic [DW-1:0]        bus_wdata_q, bus_wdata_d;

  logic                 slot_start_s, slot_end_s, found_s;
  logic [NUM_CH-1:0]    eligible_s;
  logic [CW-1:0]        srch_s, pick_s;
  logic [AW-1:0]        sel_addr_s;
  logic [DW-1:0]        sel_wdata_s;
  logic                 sel_rw_s;

  // Next-state computation for the frame counter, arbiter, channel FSMs and outputs.
  always_comb begin
    started_d    = 1'b1;
    cnt_d        = (!started_q || cnt_q == LAST) ? '0 : cnt_q + cnt_t'(1);
    sync1_d      = host_pending;
    sync2_d      = sync1_q;
    ch_state_d   = ch_state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_valid_d  = gnt_valid_q;
    host_rdata_d = host_rdata_q;
    host_done_d  = '0;
    sel_addr_s   = '0;
    sel_wdata_s  = '0;
    sel_rw_s     = 1'b1;

    slot_start_s = started_q && (cnt_q == Q_M1);
    slot_end_s   = started_q && (cnt_q == SLOT_END);

    for (int i = 0; i < NUM_CH; i++) begin
      eligible_s[i] = (ch_state_q[i] == QUEUED) && sync2_q[i];
    end

    // Round-robin search starting just after the last granted channel.
    found_s = 1'b0;
    srch_s  = rr_ptr_q;
    pick_s  = rr_ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      srch_s  = (srch_s == CW'(NUM_CH - 1)) ? '0 : srch_s + CW'(1);
      pick_s  = (!found_s && eligible_s[srch_s]) ? srch_s : pick_s;
      found_s = found_s | eligible_s[srch_s];
    end

    if (slot_start_s) begin
      gnt_valid_d = found_s;
      gnt_idx_d   = found_s ? pick_s : gnt_idx_q;
      rr_ptr_d    = found_s ? pick_s : rr_ptr_q;
    end else if (slot_end_s) begin
      gnt_valid_d = 1'b0;
    end else begin
      gnt_valid_d = gnt_valid_q;
    end

    for (int i = 0; i < NUM_CH; i++) begin
      case (ch_state_q[i])
        IDLE:    ch_state_d[i] = sync2_q[i] ? QUEUED : IDLE;
        QUEUED: begin
          if (!sync2_q[i]) begin
            ch_state_d[i] = IDLE;
          end else if (slot_start_s && found_s && pick_s == CW'(i)) begin
            ch_state_d[i] = ACTIVE;
          end else begin
            ch_state_d[i] = QUEUED;
          end
        end
        ACTIVE:  ch_state_d[i] = slot_end_s ? DONE : ACTIVE;
        DONE:    ch_state_d[i] = sync2_q[i] ? DONE : IDLE;
        default: ch_state_d[i] = IDLE;
      endcase
      host_done_d[i] = (ch_state_d[i] == DONE);
      // bus_rw_b_q is the direction latched for the slot now ending.
      if (slot_end_s && gnt_valid_q && gnt_idx_q == CW'(i) && bus_rw_b_q) begin
        host_rdata_d[i*DW +: DW] = bus_rdata;
      end else begin
        host_rdata_d[i*DW +: DW] = host_rdata_q[i*DW +: DW];
      end
      if (gnt_idx_d == CW'(i)) begin
        sel_addr_s  = host_addr[i*AW +: AW];
        sel_wdata_s = host_wdata[i*DW +: DW];
        sel_rw_s    = host_rw_b[i];
      end else begin
        sel_addr_s  = sel_addr_s;
        sel_wdata_s = sel_wdata_s;
        sel_rw_s    = sel_rw_s;
      end
    end

    vid_sel_d  = (cnt_d < Q_LO);
    vid_stb_d  = (cnt_d == Q_M1);
    cpu_sel_d  = (cnt_d >= CPU_LO);
    phi2_d     = (cnt_d >= PHI_LO);
    host_sel_d = gnt_valid_d;
    host_rd_d  = gnt_valid_d && (cnt_d == SLOT_END) && sel_rw_s;
    host_wr_d  = gnt_valid_d && (cnt_d == SLOT_END) && !sel_rw_s;

    if (gnt_valid_d) begin
      bus_addr_d  = sel_addr_s;
      bus_wdata_d = sel_wdata_s;
      bus_rw_b_d  = sel_rw_s;
    end else begin
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_rw_b_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk16 or negedge reset_b) begin
    if (!reset_b) begin
      started_q    <= 1'b0;
      cnt_q        <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_state_q[i] <= IDLE;
      rr_ptr_q     <= CW'(NUM_CH - 1);
      gnt_idx_q    <= '0;
      gnt_valid_q  <= 1'b0;
      phi2_q       <= 1'b0;
      cpu_sel_q    <= 1'b0;
      vid_sel_q    <= 1'b0;
      vid_stb_q    <= 1'b0;
      host_sel_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      host_wr_q    <= 1'b0;
      host_done_q  <= '0;
      host_rdata_q <= '0;
      bus_addr_q   <= '0;
      bus_rw_b_q   <= 1'b1;
      bus_wdata_q  <= '0;
    end else begin
      started_q    <= started_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      ch_state_q   <= ch_state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_valid_q  <= gnt_valid_d;
      phi2_q       <= phi2_d;
      cpu_sel_q    <= cpu_sel_d;
      vid_sel_q    <= vid_sel_d;
      vid_stb_q    <= vid_stb_d;
      host_sel_q   <= host_sel_d;
      host_rd_q    <= host_rd_d;
      host_wr_q    <= host_wr_d;
      host_done_q  <= host_done_d;
      host_rdata_q <= host_rdata_d;
      bus_addr_q   <= bus_addr_d;
      bus_rw_b_q   <= bus_rw_b_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  assign phi2         = phi2_q;
  assign cpu_select   = cpu_sel_q;
  assign video_select = vid_sel_q;
  assign video_strobe = vid_stb_q;
  assign host_select  = host_sel_q;
  assign host_read    = host_rd_q;
  assign host_write   = host_wr_q;
  assign host_done    = host_done_q;
  assign host_rdata   = host_rdata_q;
  assign bus_addr_out = bus_addr_q;
  assign bus_rw_b_out = bus_rw_b_q;
  assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: default build plus a CLK_DIV=8 / NUM_CH=4 build.
module tb_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        phi2, cpu_sel, vid_sel, vid_stb, h_sel, h_rd, h_wr, rw_out;
  logic [1:0]  pend, done, rw_b;
  logic [33:0] addr;
  logic [15:0] wdata, rdata;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wd, bus_rd;

  logic        phi2_2, cpu_sel2, vid_sel2, vid_stb2, h_sel2, h_rd2, h_wr2, rw_out2;
  logic [3:0]  pend2, done2, rw_b2;
  logic [67:0] addr2;
  logic [31:0] wdata2, rdata2;
  logic [16:0] bus_addr2;
  logic [7:0]  bus_wd2, bus_rd2;

  bus_sequencer dut (
    .clk16(clk), .reset_b(rst_n), .phi2(phi2), .cpu_select(cpu_sel), .video_select(vid_sel),
    .video_strobe(vid_stb), .host_select(h_sel), .host_read(h_rd), .host_write(h_wr),
    .host_pending(pend), .host_done(done), .host_rw_b(rw_b), .host_addr(addr),
    .host_wdata(wdata), .host_rdata(rdata), .bus_addr_out(bus_addr), .bus_rw_b_out(rw_out),
    .bus_wdata(bus_wd), .bus_rdata(bus_rd));

  bus_sequencer #(.CLK_DIV(8), .NUM_CH(4)) dut2 (
    .clk16(clk), .reset_b(rst_n), .phi2(phi2_2), .cpu_select(cpu_sel2), .video_select(vid_sel2),
    .video_strobe(vid_stb2), .host_select(h_sel2), .host_read(h_rd2), .host_write(h_wr2),
    .host_pending(pend2), .host_done(done2), .host_rw_b(rw_b2), .host_addr(addr2),
    .host_wdata(wdata2), .host_rdata(rdata2), .bus_addr_out(bus_addr2), .bus_rw_b_out(rw_out2),
    .bus_wdata(bus_wd2), .bus_rdata(bus_rd2));

  int n_cmp = 0;
  int n_fail = 0;
  int m_cnt, m_cnt2;

  // Reference frame counters: -1 in reset, 0 on the first edge after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= -1;
      m_cnt2 <= -1;
    end else begin
      m_cnt  <= (m_cnt == 15) ? 0 : m_cnt + 1;
      m_cnt2 <= (m_cnt2 == 7) ? 0 : m_cnt2 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cnt(input int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_cnt != c && n < 40);
    if (m_cnt != c) chk("wait_cnt_timeout", 64'(m_cnt), 64'(c));
  endtask

  task automatic wait_cnt2(input int c);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_cnt2 != c && n < 40);
    if (m_cnt2 != c) chk("wait_cnt2_timeout", 64'(m_cnt2), 64'(c));
  endtask

  // Checks one whole default-build frame; g<0 means no channel should be served.
  task automatic check_frame(input string tag, input int g, input logic rw,
                             input logic [16:0] a, input logic [7:0] wd);
    int  c;
    logic slot;
    wait_cnt(0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      c = m_cnt;
      slot = (g >= 0) && (c >= 4) && (c <= 7);
      chk({tag, "_hsel"}, 64'(h_sel), 64'(slot));
      chk({tag, "_hread"}, 64'(h_rd), 64'(slot && c == 7 && rw));
      chk({tag, "_hwrite"}, 64'(h_wr), 64'(slot && c == 7 && !rw));
      chk({tag, "_rwb"}, 64'(rw_out), 64'(slot ? rw : 1'b1));
      chk({tag, "_vsel"}, 64'(vid_sel), 64'(c < 4));
      chk({tag, "_vstb"}, 64'(vid_stb), 64'(c == 3));
      chk({tag, "_cpu"}, 64'(cpu_sel), 64'(c >= 8));
      chk({tag, "_phi2"}, 64'(phi2), 64'(c >= 9));
      if (g >= 0 && c >= 4) begin
        chk({tag, "_addr"}, 64'(bus_addr), 64'(a));
        chk({tag, "_wdata"}, 64'(bus_wd), 64'(wd));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pend = '0; rw_b = '1; addr = '0; wdata = '0; bus_rd = '0;
    pend2 = '0; rw_b2 = '1; addr2 = '0; wdata2 = '0; bus_rd2 = '0;
    repeat (3) @(negedge clk);

    chk("rst_phi2", 64'(phi2), 64'd0);
    chk("rst_cpu", 64'(cpu_sel), 64'd0);
    chk("rst_vsel", 64'(vid_sel), 64'd0);
    chk("rst_vstb", 64'(vid_stb), 64'd0);
    chk("rst_hsel", 64'(h_sel), 64'd0);
    chk("rst_strobes", 64'({h_rd, h_wr}), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_baddr", 64'(bus_addr), 64'd0);
    chk("rst_bwdata", 64'(bus_wd), 64'd0);
    chk("rst_rwb", 64'(rw_out), 64'd1);
    chk("rst_vsel2", 64'(vid_sel2), 64'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge_vsel", 64'(vid_sel), 64'd1);
    chk("first_edge_cpu", 64'(cpu_sel), 64'd0);

    for (int f = 0; f < 3; f++) check_frame("idle", -1, 1'b1, 17'h0, 8'h0);

    // Single read on channel 0.
    wait_cnt(8);
    addr[16:0] = 17'h08000; rw_b = 2'b11; bus_rd = 8'h5A; pend = 2'b01;
    check_frame("rd0", 0, 1'b1, 17'h08000, 8'h00);
    chk("rd0_rdata", 64'(rdata), 64'h005A);
    chk("rd0_done", 64'(done), 64'h1);
    check_frame("rd0_hold", -1, 1'b1, 17'h0, 8'h0);
    chk("rd0_done_held", 64'(done), 64'h1);
    pend = 2'b00;
    repeat (3) @(negedge clk);
    chk("rd0_done_clr", 64'(done), 64'h0);
    chk("rd0_rdata_held", 64'(rdata), 64'h005A);

    // Contention from a fresh reset: channel 0 first, then channel 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(8);
    addr = {17'h1AAAA, 17'h05555}; wdata = {8'hB1, 8'hB0}; rw_b = 2'b11; bus_rd = 8'h11;
    pend = 2'b11;
    check_frame("con0", 0, 1'b1, 17'h05555, 8'hB0);
    chk("con0_done", 64'(done), 64'h1);
    bus_rd = 8'h22;
    check_frame("con1", 1, 1'b1, 17'h1AAAA, 8'hB1);
    chk("con1_done", 64'(done), 64'h3);
    chk("con_rdata", 64'(rdata), 64'h2211);
    pend = 2'b00;
    repeat (3) @(negedge clk);
    chk("con_done_clr", 64'(done), 64'h0);

    // Write on channel 1.
    wait_cnt(8);
    addr[33:17] = 17'h0E80F; wdata[15:8] = 8'h03; rw_b = 2'b01; pend = 2'b10;
    check_frame("wr1", 1, 1'b0, 17'h0E80F, 8'h03);
    chk("wr1_done", 64'(done), 64'h2);
    chk("wr1_rdata_kept", 64'(rdata), 64'h2211);
    pend = 2'b00;
    repeat (3) @(negedge clk);
    chk("wr1_done_clr", 64'(done), 64'h0);

    // Withdraw while queued.
    wait_cnt(8);
    rw_b = 2'b11; pend = 2'b01;
    wait_cnt(13);
    pend = 2'b00;
    check_frame("wdraw", -1, 1'b1, 17'h0, 8'h0);
    chk("wdraw_done", 64'(done), 64'h0);

    // Reset in the middle of a granted write slot.
    wait_cnt(8);
    rw_b = 2'b10; wdata[7:0] = 8'h77; pend = 2'b01;
    wait_cnt(0);
    wait_cnt(5);
    chk("pre_rst_hsel", 64'(h_sel), 64'd1);
    chk("pre_rst_rwb", 64'(rw_out), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hsel", 64'(h_sel), 64'd0);
    chk("mid_rst_rwb", 64'(rw_out), 64'd1);
    chk("mid_rst_baddr", 64'(bus_addr), 64'd0);
    chk("mid_rst_bwdata", 64'(bus_wd), 64'd0);
    chk("mid_rst_rdata", 64'(rdata), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_clocks", 64'({phi2, cpu_sel, vid_sel, vid_stb}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rst_hwrite", 64'(h_wr), 64'd0);
    end

    // Pending still high across release is served as a new request.
    rst_n = 1'b1;
    check_frame("post_rst", 0, 1'b0, 17'h05555, 8'h77);
    chk("post_rst_done", 64'(done), 64'h1);
    pend = 2'b00;
    repeat (3) @(negedge clk);
    chk("post_rst_done_clr", 64'(done), 64'h0);

    // Second build: Q=2, four simultaneous reads served 0,1,2,3.
    for (int i = 0; i < 4; i++) addr2[i*17 +: 17] = 17'h10000 + 17'(i);
    rw_b2 = 4'hF; bus_rd2 = 8'hC3;
    wait_cnt2(4);
    pend2 = 4'hF;
    wait_cnt2(0);
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < 8; c++) begin
        if (f > 0 || c > 0) @(negedge clk);
        chk("sw_cnt", 64'(m_cnt2), 64'(c));
        chk("sw_hsel", 64'(h_sel2), 64'(c == 2 || c == 3));
        chk("sw_hread", 64'(h_rd2), 64'(c == 3));
        chk("sw_vstb", 64'(vid_stb2), 64'(c == 1));
        chk("sw_cpu", 64'(cpu_sel2), 64'(c >= 4));
        chk("sw_phi2", 64'(phi2_2), 64'(c >= 5));
        if (c == 2) chk("sw_addr", 64'(bus_addr2), 64'(17'h10000 + 17'(f)));
      end
    end
    chk("sw_done", 64'(done2), 64'hF);
    chk("sw_rdata", 64'(rdata2), 64'hC3C3C3C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
